// File: rtl/bmp_pixel_extractor_if.sv
// ---------------------------------------------------------------------------
// bmp_pixel_extractor_if
//
// Purpose: groups the data-buffer word stream (file bytes coming in) and the
// pixel stream (pixels going out to the frame writer) of bmp_pixel_extractor.
//
// Signals:
//   DB_WE          data word valid (driven by the word source)
//   DB_write_data  32-bit file word, little-endian, byte n at [8n+7:8n]
//   WordReady      extractor can take a word this cycle
//   PixValid       one-cycle pixel strobe
//   PixR/PixG/PixB pixel colour components
//   PixX/PixY      pixel coordinate, top-left origin
//
// Modports:
//   master  the environment side (word source + pixel sink)
//   slave   the extractor side
// ---------------------------------------------------------------------------
interface bmp_pixel_extractor_if #(
    parameter int COORD_LEN = 12
);
    logic                 DB_WE;
    logic [31:0]          DB_write_data;
    logic                 WordReady;
    logic                 PixValid;
    logic [7:0]           PixR;
    logic [7:0]           PixG;
    logic [7:0]           PixB;
    logic [COORD_LEN-1:0] PixX;
    logic [COORD_LEN-1:0] PixY;

    modport master (
        output DB_WE,
        output DB_write_data,
        input  WordReady,
        input  PixValid,
        input  PixR,
        input  PixG,
        input  PixB,
        input  PixX,
        input  PixY
    );

    modport slave (
        input  DB_WE,
        input  DB_write_data,
        output WordReady,
        output PixValid,
        output PixR,
        output PixG,
        output PixB,
        output PixX,
        output PixY
    );
endinterface

// File: rtl/bmp_pixel_extractor.sv
// ---------------------------------------------------------------------------
// bmp_pixel_extractor
//
// Purpose: after the BMP header has been accepted, re-reads the file from
// byte 0 as 32-bit words, skips to the pixel array, unpacks 24-bit BGR
// pixels, drops the per-row padding and emits one pixel per strobe with its
// X/Y coordinate (rows are stored bottom-up, so the first pixel is at
// (0, Height-1)).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ExtractEn         level request: rising edge starts, low aborts/acks
//   PixArrayOffset    byte offset of the pixel array (sampled on start)
//   PixWidth          width in pixels (sampled on start)
//   PixHeight         height in rows, signed (sampled on start)
//   bus               word input / pixel output interface (slave side)
//   ExtractComplite   frame finished successfully (held while ExtractEn)
//   ExtractFail       parameters rejected (held while ExtractEn)
// ---------------------------------------------------------------------------
module bmp_pixel_extractor #(
    parameter int COORD_LEN = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ExtractEn,
    input  logic [31:0]          PixArrayOffset,
    input  logic [31:0]          PixWidth,
    input  logic [31:0]          PixHeight,
    bmp_pixel_extractor_if.slave bus,
    output logic                 ExtractComplite,
    output logic                 ExtractFail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SKIP,
        S_PIXEL,
        S_PAD,
        S_DONE,
        S_FAIL
    } state_t;

    state_t state_reg, state_next;

    // Byte FIFO kept as a 64-bit shift vector: byte k of the FIFO sits at
    // [8k+7:8k]. Bytes at positions >= count are always zero, so a push can
    // simply be OR-ed in above the surviving bytes.
    logic [63:0] fifo_reg, fifo_next;
    logic [3:0]  count_reg, count_next;

    logic        en_prev_reg;
    logic [31:0] offset_reg, offset_next;
    logic [31:0] width_reg, width_next;
    logic [31:0] height_reg, height_next;
    logic [31:0] skip_reg, skip_next;

    logic [COORD_LEN-1:0] x_reg, x_next;
    logic [COORD_LEN-1:0] row_reg, row_next;
    logic [1:0]           pad_cnt_reg, pad_cnt_next;

    logic                 valid_reg, valid_next;
    logic [7:0]           r_reg, r_next;
    logic [7:0]           g_reg, g_next;
    logic [7:0]           b_reg, b_next;
    logic [COORD_LEN-1:0] px_reg, px_next;
    logic [COORD_LEN-1:0] py_reg, py_next;
    logic                 done_reg, done_next;
    logic                 fail_reg, fail_next;

    logic [1:0] pop;
    logic       push_en;
    logic       push;
    logic       flush;
    logic [3:0] base;
    logic       word_ready;
    logic       active;
    logic       bad_params;
    logic [7:0] head [0:2];

    logic [COORD_LEN-1:0] x_last;
    logic [COORD_LEN-1:0] h_last;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_head
            assign head[gi] = fifo_reg[8*gi +: 8];
        end
    endgenerate

    assign word_ready = (count_reg <= 4'd4);
    assign active     = state_reg inside {S_CHECK, S_SKIP, S_PIXEL, S_PAD};
    assign x_last     = width_reg[COORD_LEN-1:0] - COORD_LEN'(1);
    assign h_last     = height_reg[COORD_LEN-1:0] - COORD_LEN'(1);

    // Negative height means a top-down bitmap, which is not supported.
    assign bad_params = (width_reg == 32'd0) || (height_reg == 32'd0) ||
                        height_reg[31] ||
                        ((width_reg >> COORD_LEN) != 32'd0) ||
                        ((height_reg >> COORD_LEN) != 32'd0);

    // Next-state and output logic.
    always_comb begin
        state_next   = state_reg;
        offset_next  = offset_reg;
        width_next   = width_reg;
        height_next  = height_reg;
        skip_next    = skip_reg;
        x_next       = x_reg;
        row_next     = row_reg;
        pad_cnt_next = pad_cnt_reg;
        valid_next   = 1'b0;
        r_next       = r_reg;
        g_next       = g_reg;
        b_next       = b_reg;
        px_next      = px_reg;
        py_next      = py_reg;
        done_next    = done_reg;
        fail_next    = fail_reg;
        pop          = 2'd0;
        push_en      = 1'b0;
        flush        = 1'b0;

        if (active && !ExtractEn) begin
            state_next = S_IDLE;
            flush      = 1'b1;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (ExtractEn && !en_prev_reg) begin
                        offset_next  = PixArrayOffset;
                        width_next   = PixWidth;
                        height_next  = PixHeight;
                        skip_next    = 32'd0;
                        x_next       = '0;
                        row_next     = '0;
                        pad_cnt_next = 2'd0;
                        flush        = 1'b1;
                        state_next   = S_CHECK;
                    end
                end
                S_CHECK: begin
                    push_en = 1'b1;
                    if (bad_params) begin
                        state_next = S_FAIL;
                        fail_next  = 1'b1;
                        flush      = 1'b1;
                    end else if (offset_reg == 32'd0) begin
                        state_next = S_PIXEL;
                    end else begin
                        state_next = S_SKIP;
                    end
                end
                S_SKIP: begin
                    push_en = 1'b1;
                    if (count_reg != 4'd0) begin
                        pop       = 2'd1;
                        skip_next = skip_reg + 32'd1;
                        if (skip_reg + 32'd1 == offset_reg) begin
                            state_next = S_PIXEL;
                        end
                    end
                end
                S_PIXEL: begin
                    push_en = 1'b1;
                    if (count_reg >= 4'd3) begin
                        pop        = 2'd3;
                        valid_next = 1'b1;
                        b_next     = head[0];
                        g_next     = head[1];
                        r_next     = head[2];
                        px_next    = x_reg;
                        // Rows arrive bottom-up.
                        py_next    = h_last - row_reg;
                        if (x_reg == x_last) begin
                            if (row_reg == h_last) begin
                                // Trailing padding and any further words are dropped.
                                state_next = S_DONE;
                                done_next  = 1'b1;
                                flush      = 1'b1;
                            end else begin
                                x_next   = '0;
                                row_next = row_reg + COORD_LEN'(1);
                                // Row padding equals width mod 4 (3*W rounded up to 4).
                                if (width_reg[1:0] != 2'd0) begin
                                    pad_cnt_next = 2'd0;
                                    state_next   = S_PAD;
                                end
                            end
                        end else begin
                            x_next = x_reg + COORD_LEN'(1);
                        end
                    end
                end
                S_PAD: begin
                    push_en = 1'b1;
                    if (count_reg != 4'd0) begin
                        pop = 2'd1;
                        if (pad_cnt_reg + 2'd1 == width_reg[1:0]) begin
                            state_next = S_PIXEL;
                        end else begin
                            pad_cnt_next = pad_cnt_reg + 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!ExtractEn) begin
                        done_next  = 1'b0;
                        state_next = S_IDLE;
                    end
                end
                S_FAIL: begin
                    if (!ExtractEn) begin
                        fail_next  = 1'b0;
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Byte FIFO update: pop from the front, then append a pushed word just
    // above whatever survived the pop. A push is only possible with
    // count <= 4, so the four new bytes always fit.
    always_comb begin
        base = count_reg - {2'b00, pop};
        push = push_en && !flush && bus.DB_WE && word_ready;
        if (flush) begin
            fifo_next  = 64'd0;
            count_next = 4'd0;
        end else begin
            fifo_next  = fifo_reg >> {pop, 3'b000};
            count_next = base;
            if (push) begin
                fifo_next  = fifo_next | ({32'd0, bus.DB_write_data} << {base, 3'b000});
                count_next = base + 4'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            fifo_reg    <= 64'd0;
            count_reg   <= 4'd0;
            en_prev_reg <= 1'b0;
            offset_reg  <= 32'd0;
            width_reg   <= 32'd0;
            height_reg  <= 32'd0;
            skip_reg    <= 32'd0;
            x_reg       <= '0;
            row_reg     <= '0;
            pad_cnt_reg <= 2'd0;
            valid_reg   <= 1'b0;
            r_reg       <= 8'd0;
            g_reg       <= 8'd0;
            b_reg       <= 8'd0;
            px_reg      <= '0;
            py_reg      <= '0;
            done_reg    <= 1'b0;
            fail_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            fifo_reg    <= fifo_next;
            count_reg   <= count_next;
            en_prev_reg <= ExtractEn;
            offset_reg  <= offset_next;
            width_reg   <= width_next;
            height_reg  <= height_next;
            skip_reg    <= skip_next;
            x_reg       <= x_next;
            row_reg     <= row_next;
            pad_cnt_reg <= pad_cnt_next;
            valid_reg   <= valid_next;
            r_reg       <= r_next;
            g_reg       <= g_next;
            b_reg       <= b_next;
            px_reg      <= px_next;
            py_reg      <= py_next;
            done_reg    <= done_next;
            fail_reg    <= fail_next;
        end
    end

    assign bus.WordReady   = word_ready;
    assign bus.PixValid    = valid_reg;
    assign bus.PixR        = r_reg;
    assign bus.PixG        = g_reg;
    assign bus.PixB        = b_reg;
    assign bus.PixX        = px_reg;
    assign bus.PixY        = py_reg;
    assign ExtractComplite = done_reg;
    assign ExtractFail     = fail_reg;

endmodule

// File: tb/tb_bmp_pixel_extractor.sv
// ---------------------------------------------------------------------------
// tb_bmp_pixel_extractor
//
// Purpose: randomized bench for bmp_pixel_extractor. A random file image is
// streamed as little-endian words; every emitted pixel is compared against a
// reference that indexes the file image directly (offset + row * stride +
// 3 * x, stride = 3*W rounded up to 4).
// ---------------------------------------------------------------------------
module tb_bmp_pixel_extractor;
    localparam int CL = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ExtractEn = 1'b0;
    logic [31:0] PixArrayOffset = 32'd0;
    logic [31:0] PixWidth = 32'd0;
    logic [31:0] PixHeight = 32'd0;
    logic        ExtractComplite;
    logic        ExtractFail;

    bmp_pixel_extractor_if #(.COORD_LEN(CL)) bus ();

    bmp_pixel_extractor #(.COORD_LEN(CL)) dut (
        .clk             (clk),
        .rst             (rst),
        .ExtractEn       (ExtractEn),
        .PixArrayOffset  (PixArrayOffset),
        .PixWidth        (PixWidth),
        .PixHeight       (PixHeight),
        .bus             (bus.slave),
        .ExtractComplite (ExtractComplite),
        .ExtractFail     (ExtractFail)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  file_mem [0:4095];
    bit          stream_on = 1'b0;
    int          stream_mode = 0;
    logic [47:0] got_q [$];
    int          frame_base = 0;
    int          wr_low_cnt = 0;

    // driver-owned state
    int drv_idx = 0;
    int drv_cyc = 0;
    bit drv_adv = 1'b0;
    bit drv_we = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_at(input int idx);
        int a;
        a = (idx % 1024) * 4;
        return {file_mem[a+3], file_mem[a+2], file_mem[a+1], file_mem[a]};
    endfunction

    function automatic logic [47:0] exp_pix(input int w, input int h, input int off, input int i);
        int row;
        int x;
        int stride;
        int idx;
        row    = i / w;
        x      = i % w;
        stride = ((3 * w + 3) / 4) * 4;
        idx    = off + row * stride + 3 * x;
        return {CL'(x), CL'(h - 1 - row), file_mem[idx+2], file_mem[idx+1], file_mem[idx]};
    endfunction

    // Word source: the acceptance decision is made at the negedge where the
    // word is presented, because WordReady is stable until the next posedge.
    initial begin
        bus.DB_WE = 1'b0;
        bus.DB_write_data = 32'd0;
        forever begin
            @(negedge clk);
            if (!stream_on) begin
                drv_idx = 0;
                drv_cyc = 0;
                drv_adv = 1'b0;
                drv_we  = 1'b0;
            end else begin
                if (drv_adv) drv_idx++;
                drv_we = (stream_mode == 0) || (drv_cyc % 3 == 0);
                drv_cyc++;
            end
            bus.DB_WE = drv_we;
            bus.DB_write_data = word_at(drv_idx);
            drv_adv = drv_we && bus.WordReady;
        end
    end

    // Pixel monitor.
    always @(negedge clk) begin
        if (bus.PixValid === 1'b1)
            got_q.push_back({bus.PixX, bus.PixY, bus.PixR, bus.PixG, bus.PixB});
        if (ExtractEn && bus.WordReady === 1'b0)
            wr_low_cnt <= wr_low_cnt + 1;
    end

    task automatic start_frame(input int w, input int h, input int off, input int mode, input bit new_file);
        if (new_file)
            for (int i = 0; i < 4096; i++) file_mem[i] = 8'($urandom);
        PixWidth       = w;
        PixHeight      = h;
        PixArrayOffset = off;
        stream_mode    = mode;
        step();
        frame_base = got_q.size();
        ExtractEn  = 1'b1;
        stream_on  = 1'b1;
    endtask

    task automatic wait_pix(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (got_q.size() - frame_base >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input int w, input int h, input int off);
        bit ok;
        int n;
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (ExtractComplite || ExtractFail) begin
                ok = 1'b1;
                break;
            end
        end
        chk("frame_timeout", ok, 1);
        n = got_q.size() - frame_base;
        chk("npix", n, w * h);
        chk("complete", ExtractComplite, 1);
        chk("fail_flag", ExtractFail, 0);
        chk("done_wr", bus.WordReady, 1);
        for (int i = 0; i < n && i < w * h; i++)
            chk("pix", got_q[frame_base + i], exp_pix(w, h, off, i));
        ExtractEn = 1'b0;
        step();
        chk("complete_clr", ExtractComplite, 0);
        stream_on = 1'b0;
        step();
        step();
        chk("npix_after", got_q.size() - frame_base, w * h);
        $display("frame w=%0d h=%0d off=%0d mode=%0d pixels=%0d", w, h, off, stream_mode, n);
    endtask

    task automatic fail_case(input logic [31:0] w, input logic [31:0] h);
        PixWidth       = w;
        PixHeight      = h;
        PixArrayOffset = 32'd0;
        stream_mode    = 0;
        step();
        frame_base = got_q.size();
        ExtractEn  = 1'b1;
        stream_on  = 1'b1;
        step();
        chk("fail_early", ExtractFail, 0);
        step();
        chk("fail_set", ExtractFail, 1);
        step();
        step();
        chk("fail_hold", ExtractFail, 1);
        chk("fail_wr", bus.WordReady, 1);
        chk("fail_nocomp", ExtractComplite, 0);
        chk("fail_nopix", got_q.size() - frame_base, 0);
        ExtractEn = 1'b0;
        step();
        chk("fail_clr", ExtractFail, 0);
        stream_on = 1'b0;
        step();
        $display("fail case w=%0h h=%0h", w, h);
    endtask

    initial begin
        bit ok;
        int n0;
        int wr_before;

        // reset state
        step();
        chk("reset_outs", {bus.PixValid, bus.PixR, bus.PixG, bus.PixB, bus.PixX, bus.PixY,
                           ExtractComplite, ExtractFail}, 0);
        step();
        rst = 1'b0;
        step();
        chk("idle_outs", {bus.PixValid, ExtractComplite, ExtractFail}, 0);

        // 2x2, offset 54, continuous stream
        start_frame(2, 2, 54, 0, 1'b1);
        check_frame(2, 2, 54);

        // 4x1, offset 0, no padding; buffer must fill past 4 bytes
        wr_before = wr_low_cnt;
        start_frame(4, 1, 0, 0, 1'b1);
        check_frame(4, 1, 0);
        chk("wr_low_seen", (wr_low_cnt - wr_before) > 0, 1);

        // rejected parameters
        fail_case(32'd0, 32'd3);
        fail_case(32'd4, 32'hFFFF_FFFE);
        fail_case(32'd4, 32'd0);
        fail_case(32'd4096, 32'd2);
        fail_case(32'd5, 32'd4096);

        // 3x2 with a throttled stream, then the same file streamed continuously
        start_frame(3, 2, 54, 1, 1'b1);
        check_frame(3, 2, 54);
        start_frame(3, 2, 54, 0, 1'b0);
        check_frame(3, 2, 54);

        // random frames
        for (int k = 0; k < 6; k++) begin
            int w;
            int h;
            int off;
            int mode;
            w    = int'($urandom_range(1, 9));
            h    = int'($urandom_range(1, 5));
            off  = int'($urandom_range(0, 80));
            mode = int'($urandom_range(0, 1));
            start_frame(w, h, off, mode, 1'b1);
            check_frame(w, h, off);
        end

        // abort mid-row, then restart on the same file
        start_frame(5, 3, 20, 0, 1'b1);
        wait_pix(3, 2000, ok);
        chk("abort_reach", ok, 1);
        ExtractEn = 1'b0;
        n0 = got_q.size() - frame_base;
        for (int c = 0; c < 10; c++) step();
        chk("abort_nopix", got_q.size() - frame_base, n0);
        chk("abort_nocomp", ExtractComplite, 0);
        for (int i = 0; i < n0 && i < 15; i++)
            chk("abort_pix", got_q[frame_base + i], exp_pix(5, 3, 20, i));
        $display("abort after %0d pixels", n0);
        stream_on = 1'b0;
        step();
        start_frame(5, 3, 20, 0, 1'b0);
        check_frame(5, 3, 20);

        // asynchronous reset mid-frame
        start_frame(6, 3, 10, 0, 1'b1);
        wait_pix(2, 2000, ok);
        chk("rst_reach", ok, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_outs", {bus.PixValid, bus.PixR, bus.PixG, bus.PixB, bus.PixX, bus.PixY,
                               ExtractComplite, ExtractFail}, 0);
        $display("async reset applied mid-frame");
        ExtractEn = 1'b0;
        stream_on = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        start_frame(6, 3, 10, 0, 1'b0);
        check_frame(6, 3, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
